// File: rtl/dmac_cmd_master.sv
// dmac_cmd_master
// Bus initiator for master port M0. For each accepted command it programs the
// DMAC (src, dst, size, opstart), waits for the DMAC interrupt or a timeout,
// clears the interrupt, then pulses done with a completion code.
//
// Parameters:
//   DMAC_BASE  bus address of DMAC register 0 (+0 src .. +4 interrupt clear)
//   TIMEOUT    cycles to wait for D_interrupt before giving up (1..65535)
// Optional feature macro: DMAC_CMD_READBACK_EN
//   When defined, the size register is read back before opstart. A mismatch
//   skips the start and reports err=3.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_src/cmd_dst/cmd_size       command fields (size 0 rejected)
//   done/err                       one-cycle completion pulse and code
//   M_req/M_wr/M_address/M_dout    bus request, write strobe, address, data
//   M_grant/M_din                  bus grant and read data
//   D_interrupt                    DMAC completion interrupt (level)
module dmac_cmd_master #(
    parameter logic [7:0]  DMAC_BASE = 8'h00,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_src,
    input  logic [7:0]  cmd_dst,
    input  logic [7:0]  cmd_size,
    output logic        done,
    output logic [1:0]  err,
    output logic        M_req,
    output logic        M_wr,
    output logic [7:0]  M_address,
    output logic [31:0] M_dout,
    input  logic        M_grant,
    input  logic [31:0] M_din,
    input  logic        D_interrupt
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_W_SRC, S_W_DST, S_W_SIZE,
`ifdef DMAC_CMD_READBACK_EN
        S_RB,
`endif
        S_W_START, S_WAIT, S_ARB2, S_W_CLR, S_FIN
    } state_t;

    localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  src_q, src_d, dst_q, dst_d, size_q, size_d;
    logic [1:0]  code_q, code_d;
    logic [15:0] cnt_q, cnt_d;
    logic        irq_q;
    logic        cmd_ready_q, cmd_ready_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        req_q, req_d, wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic        accept;
`ifdef DMAC_CMD_READBACK_EN
    // 0: issuing the read beat, 1: read data arrives this cycle
    logic        rb_phase_q, rb_phase_d;
`endif

    // Only the low byte of read data is ever inspected
    logic unused_din;
    assign unused_din = ^M_din;

    assign accept = cmd_valid & cmd_ready_q & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        size_d  = size_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
`ifdef DMAC_CMD_READBACK_EN
        rb_phase_d = rb_phase_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                src_d  = cmd_src;
                dst_d  = cmd_dst;
                size_d = cmd_size;
                if (cmd_size == 8'd0) begin
                    code_d  = 2'd1;
                    state_d = S_FIN;
                end else begin
                    code_d  = 2'd0;
                    state_d = S_ARB;
                end
            end
            S_ARB:    if (M_grant) state_d = S_W_SRC;
            S_W_SRC:  if (M_grant) state_d = S_W_DST;
            S_W_DST:  if (M_grant) state_d = S_W_SIZE;
            S_W_SIZE: if (M_grant) begin
`ifdef DMAC_CMD_READBACK_EN
                rb_phase_d = 1'b0;
                state_d    = S_RB;
`else
                state_d    = S_W_START;
`endif
            end
`ifdef DMAC_CMD_READBACK_EN
            S_RB: begin
                if (!rb_phase_q) begin
                    if (M_grant) rb_phase_d = 1'b1;
                end else begin
                    rb_phase_d = 1'b0;
                    if (M_din[7:0] == size_q) begin
                        state_d = S_W_START;
                    end else begin
                        code_d  = 2'd3;
                        state_d = S_ARB2;
                    end
                end
            end
`endif
            S_W_START: if (M_grant) begin
                cnt_d   = TIMEOUT_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 16'd1;
                // Interrupt has priority over a simultaneous expiry
                if (irq_q) begin
                    state_d = S_ARB2;
                end else if (cnt_q == 16'd1) begin
                    code_d  = 2'd2;
                    state_d = S_ARB2;
                end
            end
            S_ARB2:  if (M_grant) state_d = S_W_CLR;
            S_W_CLR: if (M_grant) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered copies of what the next state presents
        req_d  = 1'b0;
        wr_d   = 1'b0;
        addr_d = 8'h00;
        dout_d = 32'h0;
        case (state_d)
            S_ARB, S_ARB2: req_d = 1'b1;
            S_W_SRC: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = DMAC_BASE;
                dout_d = {24'h0, src_d};
            end
            S_W_DST: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = DMAC_BASE + 8'd1;
                dout_d = {24'h0, dst_d};
            end
            S_W_SIZE: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = DMAC_BASE + 8'd2;
                dout_d = {24'h0, size_d};
            end
`ifdef DMAC_CMD_READBACK_EN
            S_RB: begin
                req_d = 1'b1; addr_d = DMAC_BASE + 8'd2;
            end
`endif
            S_W_START: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = DMAC_BASE + 8'd3;
                dout_d = 32'h1;
            end
            S_W_CLR: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = DMAC_BASE + 8'd4;
            end
            default: ;
        endcase

        // done follows FIN by one cycle; ready comes back the cycle after done
        done_d      = (state_q == S_FIN);
        err_d       = (state_q == S_FIN) ? code_q : 2'd0;
        cmd_ready_d = (state_q == S_IDLE) & ~accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_q       <= 8'h0;
            dst_q       <= 8'h0;
            size_q      <= 8'h0;
            code_q      <= 2'd0;
            cnt_q       <= 16'd0;
            irq_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 2'd0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h0;
            dout_q      <= 32'h0;
`ifdef DMAC_CMD_READBACK_EN
            rb_phase_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            size_q      <= size_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            irq_q       <= D_interrupt;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
`ifdef DMAC_CMD_READBACK_EN
            rb_phase_q  <= rb_phase_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign M_req     = req_q;
    assign M_wr      = wr_q;
    assign M_address = addr_q;
    assign M_dout    = dout_q;

endmodule

// File: tb/tb_dmac_cmd_master.sv
module tb_dmac_cmd_master;

    localparam logic [7:0] BASE = 8'h00;
`ifdef DMAC_CMD_READBACK_EN
    localparam int RBX = 2;
`else
    localparam int RBX = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_src = 8'h0, cmd_dst = 8'h0, cmd_size = 8'h0;
    logic        done;
    logic [1:0]  err;
    logic        M_req, M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic        M_grant = 1'b1;
    logic [31:0] M_din = 32'h0;
    logic        D_interrupt = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;

    // Write-beat log, done capture, request rises
    logic [7:0]  w_addr[$];
    logic [31:0] w_data[$];
    int          w_edge[$];
    int          rise_cyc[$];
    logic        req_prev = 1'b0;
    int          done_cnt = 0;
    int          done_edge = 0;
    logic [1:0]  done_err = 2'd0;

    // DMAC model: interrupt irq_delay negedges after the start write
    int          irq_delay = -1;
    int          irq_timer = 0;
    logic [31:0] mem [0:255];
    logic        rb_force = 1'b0;
    logic [31:0] rb_val = 32'h0;

    dmac_cmd_master #(.DMAC_BASE(BASE), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_size(cmd_size),
        .done(done), .err(err),
        .M_req(M_req), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout),
        .M_grant(M_grant), .M_din(M_din), .D_interrupt(D_interrupt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (M_req && M_grant && M_wr) mem[M_address] <= M_dout;
        if (M_req && M_grant && !M_wr) M_din <= rb_force ? rb_val : mem[M_address];
    end

    always @(negedge clk) begin
        if (M_req && M_grant && M_wr) begin
            w_addr.push_back(M_address);
            w_data.push_back(M_dout);
            w_edge.push_back(cyc + 1);
        end
        if (M_req && !req_prev) rise_cyc.push_back(cyc);
        req_prev = M_req;
        if (done) begin
            done_cnt++;
            done_err = err;
            done_edge = cyc + 1;
        end
        if (reset) begin
            irq_timer = 0;
            D_interrupt = 1'b0;
        end else if (M_req && M_grant && M_wr && M_address == BASE + 8'd3) begin
            if (irq_delay >= 1) irq_timer = irq_delay;
        end else if (M_req && M_grant && M_wr && M_address == BASE + 8'd4) begin
            D_interrupt = 1'b0;
        end else if (irq_timer > 0) begin
            irq_timer--;
            if (irq_timer == 0) D_interrupt = 1'b1;
        end
    end

    task automatic submit(input logic [7:0] s, input logic [7:0] d, input logic [7:0] z);
        int n;
        w_addr.delete(); w_data.delete(); w_edge.delete(); rise_cyc.delete();
        done_cnt = 0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        total++;
        if (!cmd_ready) begin
            bad++;
            $display("FAIL submit_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_src = s; cmd_dst = d; cmd_size = z; cmd_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
        $display("cmd src=%h dst=%h size=%h accepted at edge %0d", s, d, z, acc);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin @(negedge clk); #1; n++; end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end else begin
            $display("done err=%0d at edge %0d (accept %0d)", done_err, done_edge, acc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({cmd_ready, done, err, M_req, M_wr} !== 6'b100000 ||
            M_address !== 8'h0 || M_dout !== 32'h0) begin
            bad++;
            $display("FAIL %s: rdy=%b done=%b err=%0d req=%b wr=%b addr=%h dout=%h required 1 0 0 0 0 00 0",
                     tag, cmd_ready, done, err, M_req, M_wr, M_address, M_dout);
        end else $display("%s outputs at reset values", tag);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] s, input logic [7:0] d,
                                input logic [7:0] z, input logic with_start);
        logic [7:0]  ea[5];
        logic [31:0] ed[5];
        int          ne;
        ea[0] = BASE;        ed[0] = {24'h0, s};
        ea[1] = BASE + 8'd1; ed[1] = {24'h0, d};
        ea[2] = BASE + 8'd2; ed[2] = {24'h0, z};
        if (with_start) begin
            ea[3] = BASE + 8'd3; ed[3] = 32'h1;
            ea[4] = BASE + 8'd4; ed[4] = 32'h0;
            ne = 5;
        end else begin
            ea[3] = BASE + 8'd4; ed[3] = 32'h0;
            ne = 4;
        end
        total++;
        if (w_addr.size() != ne) begin
            bad++;
            $display("FAIL %s_count: writes=%0d required %0d", tag, w_addr.size(), ne);
        end else begin
            for (int i = 0; i < ne; i++) begin
                total++;
                if (w_addr[i] !== ea[i] || w_data[i] !== ed[i]) begin
                    bad++;
                    $display("FAIL %s_w%0d: addr=%h data=%h required addr=%h data=%h",
                             tag, i, w_addr[i], w_data[i], ea[i], ed[i]);
                end else $display("%s write %0d addr=%h data=%h edge=%0d", tag, i, w_addr[i], w_data[i], w_edge[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic test_basic();
        irq_delay = 12;
        submit(8'h20, 8'h30, 8'h04);
        wait_done(200);
        total++;
        if (done_err !== 2'd0) begin bad++; $display("FAIL basic_err: err=%0d required 0", done_err); end
        check_writes("basic", 8'h20, 8'h30, 8'h04, 1'b1);
        if (w_edge.size() == 5) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (w_edge[i] != acc + 2 + i) begin
                    bad++;
                    $display("FAIL basic_edge%0d: edge=%0d required %0d", i, w_edge[i], acc + 2 + i);
                end
            end
            total++;
            if (w_edge[3] != acc + 5 + RBX) begin
                bad++;
                $display("FAIL basic_start_edge: edge=%0d required %0d", w_edge[3], acc + 5 + RBX);
            end
        end
        total++;
        if (done_edge != acc + 22 + RBX) begin
            bad++;
            $display("FAIL basic_done_edge: edge=%0d required %0d", done_edge, acc + 22 + RBX);
        end
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_at_done: rdy=%b required 0", cmd_ready); end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready_after: rdy=%b done=%b required 1 0", cmd_ready, done);
        end
    endtask

    task automatic test_size_zero();
        logic req_seen;
        req_seen = 1'b0;
        submit(8'h11, 8'h22, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (M_req) req_seen = 1'b1;
        end
        total++;
        if (req_seen) begin bad++; $display("FAIL zero_req: M_req=1 required 0"); end
        total++;
        if (done_cnt != 1 || done_edge != acc + 2 || done_err !== 2'd1) begin
            bad++;
            $display("FAIL zero_done: count=%0d edge=%0d err=%0d required 1 %0d 1",
                     done_cnt, done_edge, done_err, acc + 2);
        end else $display("zero: done err=1 at edge %0d", done_edge);
        total++;
        if (w_addr.size() != 0) begin bad++; $display("FAIL zero_writes: writes=%0d required 0", w_addr.size()); end
    endtask

    task automatic test_timeout();
        irq_delay = -1;
        submit(8'h40, 8'h50, 8'h08);
        wait_done(200);
        total++;
        if (done_err !== 2'd2) begin bad++; $display("FAIL timeout_err: err=%0d required 2", done_err); end
        check_writes("timeout", 8'h40, 8'h50, 8'h08, 1'b1);
        total++;
        if (rise_cyc.size() != 2 || w_edge.size() != 5) begin
            bad++;
            $display("FAIL timeout_shape: rises=%0d writes=%0d required 2 5", rise_cyc.size(), w_edge.size());
        end else if (rise_cyc[1] - w_edge[3] != 16) begin
            bad++;
            $display("FAIL timeout_gap: gap=%0d required 16", rise_cyc[1] - w_edge[3]);
        end else $display("timeout: clear request %0d cycles after start", rise_cyc[1] - w_edge[3]);
    endtask

    task automatic test_grant_stall();
        int n;
        irq_delay = 5;
        submit(8'h61, 8'h30, 8'h03);
        n = 0;
        while (!(M_req && M_wr && M_address == BASE) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        M_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (M_req !== 1'b1 || M_wr !== 1'b1 || M_address !== BASE + 8'd1 || M_dout !== 32'h30) begin
                bad++;
                $display("FAIL stall_hold%0d: req=%b wr=%b addr=%h dout=%h required 1 1 01 00000030",
                         i, M_req, M_wr, M_address, M_dout);
            end else $display("stall cycle %0d holds dst write", i);
            @(posedge clk); #1;
        end
        M_grant = 1'b1;
        wait_done(200);
        total++;
        if (done_err !== 2'd0) begin bad++; $display("FAIL stall_err: err=%0d required 0", done_err); end
        check_writes("stall", 8'h61, 8'h30, 8'h03, 1'b1);
        if (w_edge.size() == 5) begin
            total++;
            if (w_edge[1] - w_edge[0] != 4) begin
                bad++;
                $display("FAIL stall_gap: gap=%0d required 4", w_edge[1] - w_edge[0]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        irq_delay = -1;
        submit(8'h70, 8'h71, 8'h02);
        n = 0;
        while (w_addr.size() < 4 && n < 50) begin @(negedge clk); #1; n++; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        reset = 1'b0;
        n = w_addr.size();
        repeat (25) @(negedge clk);
        #1;
        total++;
        if (w_addr.size() != n || M_req !== 1'b0 || done_cnt != 0) begin
            bad++;
            $display("FAIL rst_no_clear: writes=%0d req=%b done=%0d required %0d 0 0",
                     w_addr.size(), M_req, done_cnt, n);
        end
        irq_delay = 4;
        submit(8'h81, 8'h82, 8'h83);
        wait_done(200);
        total++;
        if (done_err !== 2'd0) begin bad++; $display("FAIL rst_next_err: err=%0d required 0", done_err); end
        check_writes("rst_next", 8'h81, 8'h82, 8'h83, 1'b1);
    endtask

`ifdef DMAC_CMD_READBACK_EN
    task automatic test_readback();
        irq_delay = 4;
        rb_force = 1'b1;
        rb_val = 32'h05;
        submit(8'h90, 8'h91, 8'h04);
        wait_done(200);
        rb_force = 1'b0;
        total++;
        if (done_err !== 2'd3) begin bad++; $display("FAIL rb_err: err=%0d required 3", done_err); end
        check_writes("rb", 8'h90, 8'h91, 8'h04, 1'b0);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_size_zero();
        test_timeout();
        test_grant_stall();
        test_reset_in_wait();
`ifdef DMAC_CMD_READBACK_EN
        test_readback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmac_cmd_master.md
# dmac_cmd_master

Bus initiator that programs and runs one DMAC transfer per accepted command. It drives the master port M0 of the two-master bus system, writes the DMAC source, destination, size and start registers, waits for the DMAC interrupt, and clears it. It sits outside the bus and replaces hand-driven M0 stimulus with a command/response handshake.

## Interface
- `DMAC_BASE`, 8'h00: bus address of DMAC register 0.
- `TIMEOUT`, 1024: cycles to wait for `D_interrupt` before abort; range 1..65535.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block idle, command accepted on `cmd_valid & cmd_ready`.
- `cmd_src`  in  8  DMAC source address.
- `cmd_dst`  in  8  DMAC destination address.
- `cmd_size`  in  8  word count; 0 is illegal.
- `done`  out  1  one-cycle pulse, command finished.
- `err`  out  2  code valid with `done`: 0 ok, 1 size zero, 2 timeout, 3 readback mismatch.
- `M_req`, `M_wr`  out  1  bus request, write strobe.
- `M_address`  out  8  bus address.
- `M_dout`  out  32  write data.
- `M_grant`  in  1  bus grant to this master.
- `M_din`  in  32  read data.
- `D_interrupt`  in  1  DMAC completion interrupt, level.

## Operation
- Register offsets from `DMAC_BASE`: +0 src, +1 dst, +2 size, +3 opstart, +4 interrupt-clear. Written data is zero-extended to 32 bits; opstart write data 1, interrupt-clear write data 0.
- A bus beat completes at a rising edge where `M_req & M_grant` hold. Beats with `M_grant` low repeat unchanged.
- States: IDLE, ARB, W_SRC, W_DST, W_SIZE, RB (macro only), W_START, WAIT, ARB2, W_CLR, FIN.
- IDLE: `cmd_ready`=1. On accept, latch command. If size=0, go to FIN with err=1 and no bus activity. Otherwise go to ARB.
- ARB: `M_req`=1, `M_wr`=0. Go to W_SRC on `M_grant`.
- W_SRC, W_DST, W_SIZE, W_START: one write beat each, in that order.
- After W_START, drop `M_req` and load the timeout counter with `TIMEOUT`.
- WAIT: decrement the counter each cycle.
  - On `D_interrupt`=1, go to ARB2.
  - If the counter reaches 0, set err=2 and go to ARB2 anyway, so the DMAC is always cleared.
  - If `D_interrupt` and counter=0 occur in the same cycle, the interrupt wins (err=0).
- ARB2, then W_CLR (clear write), then FIN. FIN pulses `done` with `err` for 1 cycle, then returns to IDLE.
- `M_req` stays high continuously from ARB through W_START, and from ARB2 through W_CLR.
- Reset in any state returns to IDLE at the next edge and discards the latched command. No clear write is issued.

## Timing
- Reset values: `cmd_ready`=1; `done`, `err`, `M_req`, `M_wr`, `M_address`, `M_dout`=0.
- All outputs are registered; none depend combinationally on inputs.
- With grant held from the request cycle, the minimum accept-to-first-write latency is 2 cycles. The four writes take 4 consecutive cycles.
- `D_interrupt` is sampled registered. The response is ARB2 one cycle later.
- Minimum ok-command latency, accept to `done`: 2 + 4 + 1 (release) + interrupt wait + 1 + 2 + 1.
- The size-zero reject pulses `done` 2 cycles after accept.
- `cmd_ready` drops the cycle after accept and returns the cycle after `done`.

## Configuration
- `DMAC_CMD_READBACK_EN` defined:
  - RB state sits between W_SIZE and W_START.
  - RB issues a read of +2 and samples `M_din[7:0]` one cycle after the granted read beat (synchronous-RAM-style slave).
  - On mismatch, skip W_START and WAIT, go to ARB2, set err=3.
  - Adds 2 cycles to latency.
- Undefined: RB is absent, the W_SIZE→W_START path is direct, and err=3 is never produced.

## Test plan
- Command src=8'h20, dst=8'h30, size=8'h04, grant tied 1, DMAC raises the interrupt after 12 cycles → writes +0=0x20, +1=0x30, +2=0x04, +3=1, then +4=0; `done` with err=0.
- cmd_size=0 → `M_req` never asserts; `done` 2 cycles after accept with err=1.
- `D_interrupt` held 0, `TIMEOUT`=16 → clear write issued 16 cycles after the start write; `done` with err=2.
- `M_grant` dropped for 3 cycles during W_DST → the dst write repeats with identical address and data until granted; no beat skipped or duplicated.
- `reset` asserted during WAIT → next cycle all outputs at reset values and `cmd_ready`=1; a new command then completes normally.
- Macro defined, slave returns 0x05 on the readback → no opstart write; err=3.
